pe_accum_ctrl: RTL and testbench
================================

# pe_accum_ctrl

Sequencer that drives one shared PE adder/register pair as a running accumulator for the softmax denominator. It accepts a vector of exponentials over a valid/ready stream and feeds each element plus the PE's registered partial sum back into the PE. It pulses the PE register load on every accepted element and presents the final sum on a valid/ready result port. It sits between the exponent stage and the divider stage of the softmax pipeline.

## Interface
- DATA_WIDTH, 16, width of elements, PE operands and sum (signed, two's complement)
- LEN_WIDTH, 8, width of vector-length field; max vector length 2^LEN_WIDTH-1
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-high (1 = reset), despite the suffix
- start  in  1  begin a vector; sampled only in IDLE
- vec_len  in  LEN_WIDTH  element count, latched on accepted start
- busy  out  1  high in every state except IDLE
- s_valid  in  1  element valid
- s_data  in  DATA_WIDTH  element value (signed)
- s_ready  out  1  element accepted when s_valid & s_ready
- pe_in1  out  DATA_WIDTH  to PE in1
- pe_in2  out  DATA_WIDTH  to PE in2
- pe_set_reg  out  1  to PE set_reg; PE register loads in1+in2 at the next edge
- pe_psum_out  in  DATA_WIDTH  from PE psum_out (registered sum)
- m_valid  out  1  result valid
- m_data  out  DATA_WIDTH  result sum
- m_ready  in  1  result accepted when m_valid & m_ready
- ovf  out  1  sticky signed-overflow flag for the current vector, valid with m_valid

## Operation
- States: IDLE, CLEAR, ACCUM, RESULT. State, remaining-count and ovf are registered. PE-facing outputs, s_ready and m_valid are decoded combinationally from the state.
- IDLE: all outputs 0. On start=1, latch vec_len into cnt and go to CLEAR.
- CLEAR (1 cycle): pe_in1=0, pe_in2=0, pe_set_reg=1, so the PE register becomes 0. Clear ovf. If cnt==0, go to RESULT; otherwise go to ACCUM.
- ACCUM: s_ready=1, pe_in1=s_data, pe_in2=pe_psum_out, pe_set_reg=s_valid.
  - On each accepted beat, decrement cnt.
  - Set ovf if s_data and pe_psum_out have equal sign bits and the sign of their DATA_WIDTH-bit sum differs.
  - When the beat accepted with cnt==1, go to RESULT.
  - Bubbles (s_valid=0) hold state and cnt, and do not load the PE.
- RESULT: m_valid=1, m_data=pe_psum_out, pe_set_reg=0, so the value is stable. Stay until m_ready=1, then go to IDLE.
- Arithmetic: wrap-around modulo 2^DATA_WIDTH, identical to the PE. No saturation; overflow is reported only through ovf.
- start while busy is ignored; it is neither queued nor does it restart.
- start and m_ready both high in RESULT: the result is consumed and the state goes to IDLE. start must be reasserted in IDLE to begin a new vector.
- Reset mid-operation: the next edge forces IDLE, cnt=0, ovf=0, and all outputs 0. The PE register is not touched by reset; the next CLEAR zeroes it.

## Timing
- start sampled at edge t gives CLEAR in cycle t+1. ACCUM starts in cycle t+2, when s_ready rises.
- One element per cycle; back-to-back beats are legal. pe_psum_out already holds the updated sum in the cycle after each load.
- For N≥1 elements with no bubbles, m_valid asserts in cycle t+2+N. Each bubble adds 1 cycle.
- For N=0, m_valid asserts in cycle t+2 with m_data=0.
- m_data and ovf hold stable while m_valid=1 and m_ready=0.
- The PE adder path is combinational into the PE register. There is no extra pipeline stage between pe_in1/pe_in2 and pe_set_reg.

## Test plan
- Reset: hold rst_n=1 for 2 cycles. Expect busy, s_ready, m_valid, pe_set_reg and ovf all 0. Then start with vec_len=0. Expect m_valid at t+2, m_data=0.
- Basic sum: vec_len=4, elements 10, 20, 30, 40 back-to-back. Expect pe_set_reg high 1 cycle in CLEAR then 4 cycles in ACCUM, m_valid at t+6, m_data=100, ovf=0.
- Bubbles and backpressure: vec_len=3, elements 5, -2, 7 with 2 idle cycles between beats, and m_ready held low 3 cycles. Expect m_data=10 stable throughout, IDLE the cycle after m_ready.
- Overflow: vec_len=2, elements 32767, 1. Expect m_data=-32768 (wrapped), ovf=1. The next vector (1, 2) gives m_data=3, ovf=0.
- Stale PE contents: preload a PE sum of 999 from a previous vector, reset, then run vec_len=1 with element 7. Expect m_data=7.
- Protocol abuse: start pulsed in ACCUM and in RESULT is ignored. rst_n=1 mid-ACCUM gives IDLE next cycle with s_ready=0, and a following vector sums correctly.

Source files
------------

// File: rtl/pe_accum_ctrl.sv
// Sequencer that turns one shared PE adder/register pair into a running accumulator
// for the softmax denominator: stream in exponentials, stream out their wrapped sum.
module pe_accum_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    output logic                  busy,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] pe_in1,
    output logic [DATA_WIDTH-1:0] pe_in2,
    output logic                  pe_set_reg,
    input  logic [DATA_WIDTH-1:0] pe_psum_out,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        ACCUM  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [LEN_WIDTH-1:0]   cnt_reg;
    logic                   ovf_reg;

    logic                   accept;
    logic [DATA_WIDTH-1:0]  beat_sum;
    logic                   beat_ovf;

    assign accept   = (state_reg == ACCUM) && s_valid;
    assign beat_sum = s_data + pe_psum_out;
    // Same-sign operands whose wrapped sum flips sign mark a signed overflow.
    assign beat_ovf = (s_data[DATA_WIDTH-1] == pe_psum_out[DATA_WIDTH-1]) &&
                      (beat_sum[DATA_WIDTH-1] != s_data[DATA_WIDTH-1]);

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg   <= vec_len;
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    ovf_reg   <= 1'b0;
                    state_reg <= (cnt_reg == '0) ? RESULT : ACCUM;
                end
                ACCUM: begin
                    if (accept) begin
                        cnt_reg <= cnt_reg - LEN_WIDTH'(1);
                        if (beat_ovf) begin
                            ovf_reg <= 1'b1;
                        end
                        if (cnt_reg == LEN_WIDTH'(1)) begin
                            state_reg <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (m_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The PE register is the only datapath storage; everything here is a decode.
    always_comb begin
        busy       = 1'b0;
        s_ready    = 1'b0;
        pe_in1     = '0;
        pe_in2     = '0;
        pe_set_reg = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        ovf        = 1'b0;
        case (state_reg)
            CLEAR: begin
                busy       = 1'b1;
                pe_set_reg = 1'b1;
            end
            ACCUM: begin
                busy       = 1'b1;
                s_ready    = 1'b1;
                pe_in1     = s_data;
                pe_in2     = pe_psum_out;
                pe_set_reg = s_valid;
            end
            RESULT: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_data  = pe_psum_out;
                ovf     = ovf_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pe_accum_ctrl.sv
// Directed bench for pe_accum_ctrl with a behavioural PE register attached;
// expected sums are hand-computed constants.
module tb_pe_accum_ctrl;

    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] vec_len;
    logic          busy;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [DW-1:0] pe_in1;
    logic [DW-1:0] pe_in2;
    logic          pe_set_reg;
    logic [DW-1:0] pe_psum_out;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          ovf;

    int tests = 0;
    int fails = 0;
    int set_cnt = 0;

    pe_accum_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .busy(busy),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .pe_in1(pe_in1), .pe_in2(pe_in2), .pe_set_reg(pe_set_reg),
        .pe_psum_out(pe_psum_out), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PE register: never reset, loads in1+in2 when set_reg is high.
    initial pe_psum_out = 16'd0;
    always @(posedge clk) begin
        if (pe_set_reg) pe_psum_out <= pe_in1 + pe_in2;
        if (pe_set_reg) set_cnt <= set_cnt + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start in IDLE and check the CLEAR cycle; returns in the first cycle after CLEAR.
    task automatic run_start(input logic [LW-1:0] len);
        start   = 1'b1;
        vec_len = len;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("clear_busy", 16'(busy), 16'd1);
        check("clear_set_reg", 16'(pe_set_reg), 16'd1);
        check("clear_s_ready", 16'(s_ready), 16'd0);
        tick();
    endtask

    task automatic beat(input logic [DW-1:0] data, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            s_valid = 1'b0;
            @(negedge clk);
            check("bubble_set_reg", 16'(pe_set_reg), 16'd0);
            check("bubble_busy", 16'(busy), 16'd1);
            tick();
        end
        s_valid = 1'b1;
        s_data  = data;
        @(negedge clk);
        check("beat_s_ready", 16'(s_ready), 16'd1);
        check("beat_set_reg", 16'(pe_set_reg), 16'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic finish_result(input string tag, input logic [DW-1:0] exp_sum,
                                 input logic exp_ovf, input int hold);
        @(negedge clk);
        check({tag, "_m_valid"}, 16'(m_valid), 16'd1);
        check({tag, "_m_data"}, m_data, exp_sum);
        check({tag, "_ovf"}, 16'(ovf), 16'(exp_ovf));
        for (int h = 0; h < hold; h++) begin
            m_ready = 1'b0;
            tick();
            @(negedge clk);
            check({tag, "_hold_valid"}, 16'(m_valid), 16'd1);
            check({tag, "_hold_data"}, m_data, exp_sum);
            check({tag, "_hold_ovf"}, 16'(ovf), 16'(exp_ovf));
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_busy"}, 16'(busy), 16'd0);
        check({tag, "_idle_m_valid"}, 16'(m_valid), 16'd0);
        tick();
    endtask

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        vec_len = '0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        @(negedge clk);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_s_ready", 16'(s_ready), 16'd0);
        check("rst_m_valid", 16'(m_valid), 16'd0);
        check("rst_set_reg", 16'(pe_set_reg), 16'd0);
        check("rst_ovf", 16'(ovf), 16'd0);
        rst_n = 1'b0;
        tick();

        // Empty vector: result right after CLEAR
        run_start(8'd0);
        finish_result("len0", 16'd0, 1'b0, 0);

        // Basic sum, back-to-back
        set_cnt = 0;
        run_start(8'd4);
        beat(16'd10, 0);
        beat(16'd20, 0);
        beat(16'd30, 0);
        beat(16'd40, 0);
        check("basic_set_reg_cycles", 16'(set_cnt), 16'd5);
        finish_result("basic", 16'd100, 1'b0, 0);

        // Bubbles and backpressure
        run_start(8'd3);
        beat(16'd5, 0);
        beat(-16'sd2, 2);
        beat(16'd7, 2);
        finish_result("bubbles", 16'd10, 1'b0, 3);

        // Overflow, then a clean vector clears the flag
        run_start(8'd2);
        beat(16'd32767, 0);
        beat(16'd1, 0);
        finish_result("ovf", 16'h8000, 1'b1, 1);
        run_start(8'd2);
        beat(16'd1, 0);
        beat(16'd2, 0);
        finish_result("after_ovf", 16'd3, 1'b0, 0);

        // Stale PE contents survive reset but are zeroed by CLEAR
        run_start(8'd1);
        beat(16'd999, 0);
        finish_result("preload", 16'd999, 1'b0, 0);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("stale_pe_kept", pe_psum_out, 16'd999);
        run_start(8'd1);
        beat(16'd7, 0);
        finish_result("stale", 16'd7, 1'b0, 0);

        // start while busy is ignored in ACCUM and RESULT
        run_start(8'd3);
        beat(16'd1, 0);
        start = 1'b1;
        beat(16'd2, 0);
        start = 1'b0;
        beat(16'd3, 0);
        start = 1'b1;
        tick();
        @(negedge clk);
        check("abuse_result_valid", 16'(m_valid), 16'd1);
        check("abuse_result_data", m_data, 16'd6);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        check("abuse_idle_busy", 16'(busy), 16'd0);
        tick();
        @(negedge clk);
        check("abuse_not_queued", 16'(busy), 16'd0);

        // Reset mid-ACCUM, then a fresh vector
        run_start(8'd4);
        beat(16'd1, 0);
        beat(16'd2, 0);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 16'(busy), 16'd0);
        check("midrst_s_ready", 16'(s_ready), 16'd0);
        check("midrst_set_reg", 16'(pe_set_reg), 16'd0);
        tick();
        run_start(8'd2);
        beat(16'd100, 0);
        beat(-16'sd50, 0);
        finish_result("post_rst", 16'd50, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
